// File: rtl/pooling_unit.sv
// Lane-parallel pooling stage: D = 2**depth registered lanes that either load a
// vector or combine each lane with its butterfly partner (max or average).
module pooling_unit #(
  parameter int depth = 4,
  parameter int W     = 8
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        doPooling,
  input  logic [W*(1<<depth)-1:0]     ip,
  input  logic [4*(1<<depth)-1:0]     control,
  output logic [W*(1<<depth)-1:0]     op
);

  localparam int D = 1 << depth;

  // Packed lanes: lane j occupies bits [W*j +: W], matching the flat buses.
  logic [D-1:0][W-1:0] r_q;
  logic [D-1:0][W-1:0] r_d;

  for (genvar j = 0; j < D; j++) begin : g_lane
    localparam logic [depth-1:0] LANE = depth'(j);

    logic [3:0]       ctrl;
    logic [depth-1:0] p_idx;
    logic [W:0]       sum;
    logic [W-1:0]     own;
    logic [W-1:0]     mate;
    logic [W-1:0]     nxt;

    assign ctrl = control[4*j +: 4];
    assign own  = r_q[j];
    assign mate = r_q[p_idx];

    always_comb begin
      // Stages beyond the lane count pair a lane with itself.
      p_idx = LANE;
      if (int'(ctrl[1:0]) < depth) begin
        p_idx = LANE ^ (depth'(1) << ctrl[1:0]);
      end

      sum = {1'b0, own} + {1'b0, mate};

      nxt = own;
      if (!doPooling) begin
        nxt = ip[W*j +: W];
      end else if (ctrl[3]) begin
        if (ctrl[2]) nxt = W'(sum >> 1);
        else         nxt = (mate > own) ? mate : own;
      end
    end

    assign r_d[j] = nxt;
  end

  // NOTE: non-blocking updates make every lane see the pre-edge partner value,
  // so all lanes of a stage update simultaneously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_q <= '0;
    else        r_q <= r_d;
  end

  assign op = r_q;

endmodule

// File: tb/tb_pooling_unit.sv
// Self-checking bench for pooling_unit: directed scenarios plus randomized
// traffic compared against an array-based model of the pooling rules.
module tb_pooling_unit;

  logic        CLK;
  logic        RST_N;
  logic        doPooling;
  logic [63:0] ip;
  logic [63:0] control;
  logic [63:0] op;

  logic        doPooling2;
  logic [15:0] ip2;
  logic [15:0] control2;
  logic [15:0] op2;

  int tests_run;
  int tests_failed;

  int st[16];
  int st2[16];

  pooling_unit #(.depth(4), .W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .doPooling(doPooling),
    .ip(ip), .control(control), .op(op)
  );

  pooling_unit #(.depth(2), .W(4)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .doPooling(doPooling2),
    .ip(ip2), .control(control2), .op(op2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] pack16(input int v[16]);
    logic [63:0] b;
    b = '0;
    for (int j = 0; j < 16; j++) b[4*j +: 4] = 4'(v[j]);
    return b;
  endfunction

  // Reference: lane count 2**d, each lane combined with lane j^(2**k) or itself.
  task automatic model_step(input int d, input bit dop, input int ipv[16],
                            input int cv[16], inout int s[16]);
    int old[16];
    int k, p;
    old = s;
    for (int j = 0; j < (1 << d); j++) begin
      if (!dop) begin
        s[j] = ipv[j] % 16;
      end else if ((cv[j] & 8) != 0) begin
        k = cv[j] & 3;
        p = (k < d) ? (j ^ (1 << k)) : j;
        if ((cv[j] & 4) != 0) s[j] = (old[j] + old[p]) / 2;
        else                  s[j] = (old[j] > old[p]) ? old[j] : old[p];
      end
    end
  endtask

  task automatic cycle(input bit dop, input int ipv[16], input int cv[16]);
    doPooling = dop;
    ip        = pack16(ipv);
    control   = pack16(cv);
    model_step(4, dop, ipv, cv, st);
    @(posedge CLK);
    #1;
  endtask

  task automatic load_ramp();
    int ipv[16];
    int cv[16];
    for (int j = 0; j < 16; j++) begin ipv[j] = j; cv[j] = 0; end
    cycle(1'b0, ipv, cv);
  endtask

  task automatic test_reset();
    int ipv[16];
    int cv[16];
    logic [63:0] exp;
    RST_N = 1'b0; doPooling = 1'b0; ip = '1; control = '0;
    doPooling2 = 1'b0; ip2 = '0; control2 = '0;
    for (int j = 0; j < 16; j++) begin st[j] = 0; st2[j] = 0; end
    #2;
    tests_run++;
    if (op !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_initial: op=%h expected %h", op, 64'h0);
    end
    RST_N = 1'b1;
    for (int j = 0; j < 16; j++) begin ipv[j] = $urandom_range(1, 15); cv[j] = 0; end
    cycle(1'b0, ipv, cv);
    tests_run++;
    if (op !== pack16(st)) begin
      tests_failed++;
      $display("FAIL reset_load_random: op=%h expected %h", op, pack16(st));
    end
    #3;
    RST_N = 1'b0;
    for (int j = 0; j < 16; j++) st[j] = 0;
    #1;
    tests_run++;
    if (op !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_async: op=%h expected %h", op, 64'h0);
    end
    #2;
    RST_N = 1'b1;
    load_ramp();
    for (int j = 0; j < 16; j++) exp[4*j +: 4] = 4'(j);
    tests_run++;
    if (op !== exp) begin
      tests_failed++;
      $display("FAIL reset_release_load: op=%h expected %h", op, exp);
    end
  endtask

  task automatic test_max_stage();
    int ipv[16];
    int cv[16];
    logic [63:0] exp;
    load_ramp();
    for (int j = 0; j < 16; j++) begin ipv[j] = 0; cv[j] = 4'b1000; end
    cycle(1'b1, ipv, cv);
    for (int j = 0; j < 16; j++) exp[4*j +: 4] = 4'(j | 1);
    tests_run++;
    if (op !== exp) begin
      tests_failed++;
      $display("FAIL max_stage_k0: op=%h expected %h", op, exp);
    end
    tests_run++;
    if (op !== pack16(st)) begin
      tests_failed++;
      $display("FAIL max_stage_model: op=%h expected %h", op, pack16(st));
    end
  endtask

  task automatic test_full_reduction();
    int ipv[16];
    int cv[16];
    load_ramp();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 16; j++) begin ipv[j] = 0; cv[j] = 8 + k; end
      cycle(1'b1, ipv, cv);
      tests_run++;
      if (op !== pack16(st)) begin
        tests_failed++;
        $display("FAIL full_max_stage%0d: op=%h expected %h", k, op, pack16(st));
      end
    end
    tests_run++;
    if (op !== {16{4'hF}}) begin
      tests_failed++;
      $display("FAIL full_max_result: op=%h expected %h", op, {16{4'hF}});
    end
    for (int j = 0; j < 16; j++) begin ipv[j] = 0; cv[j] = 0; end
    cycle(1'b1, ipv, cv);
    tests_run++;
    if (op !== {16{4'hF}}) begin
      tests_failed++;
      $display("FAIL full_max_hold: op=%h expected %h", op, {16{4'hF}});
    end
  endtask

  task automatic test_avg();
    int ipv[16];
    int cv[16];
    logic [63:0] exp;
    load_ramp();
    for (int j = 0; j < 16; j++) begin ipv[j] = 0; cv[j] = 4'b1100; end
    cycle(1'b1, ipv, cv);
    for (int j = 0; j < 16; j++) exp[4*j +: 4] = 4'(j & ~1);
    tests_run++;
    if (op !== exp) begin
      tests_failed++;
      $display("FAIL avg_stage_k0: op=%h expected %h", op, exp);
    end
    for (int j = 0; j < 16; j++) cv[j] = 4'b1101;
    cycle(1'b1, ipv, cv);
    for (int j = 0; j < 16; j++) exp[4*j +: 4] = 4'((j & ~3) + 1);
    tests_run++;
    if (op !== exp) begin
      tests_failed++;
      $display("FAIL avg_stage_k1: op=%h expected %h", op, exp);
    end
    // Truncation: 15 and 14 average to 14, and no overflow of the sum.
    for (int j = 0; j < 16; j++) begin ipv[j] = (j % 2 == 0) ? 15 : 14; cv[j] = 0; end
    cycle(1'b0, ipv, cv);
    for (int j = 0; j < 16; j++) cv[j] = 4'b1100;
    cycle(1'b1, ipv, cv);
    tests_run++;
    if (op !== {16{4'hE}}) begin
      tests_failed++;
      $display("FAIL avg_truncate: op=%h expected %h", op, {16{4'hE}});
    end
  endtask

  task automatic test_mixed_hold();
    int ipv[16];
    int cv[16];
    load_ramp();
    for (int j = 0; j < 16; j++) begin ipv[j] = 0; cv[j] = 0; end
    cv[0] = 4'b1000;
    cycle(1'b1, ipv, cv);
    tests_run++;
    if (op[3:0] !== 4'd1 || op[7:4] !== 4'd1) begin
      tests_failed++;
      $display("FAIL mixed_hold_lanes01: lane0=%0d lane1=%0d expected 1 1", op[3:0], op[7:4]);
    end
    tests_run++;
    if (op !== pack16(st)) begin
      tests_failed++;
      $display("FAIL mixed_hold_model: op=%h expected %h", op, pack16(st));
    end
  endtask

  task automatic test_self_pair();
    int ipv[16];
    int cv[16];
    int i2[16];
    int c2[16];
    for (int j = 0; j < 16; j++) begin ipv[j] = 0; cv[j] = 0; i2[j] = 0; c2[j] = 0; end
    i2[0] = 3; i2[1] = 9; i2[2] = 5; i2[3] = 12;
    doPooling2 = 1'b0;
    ip2        = pack16(i2) & 64'hFFFF;
    control2   = 16'h0;
    model_step(2, 1'b0, i2, c2, st2);
    cycle(1'b1, ipv, cv);
    tests_run++;
    if (op2 !== 16'hC593) begin
      tests_failed++;
      $display("FAIL self_pair_load: op=%h expected %h", op2, 16'hC593);
    end
    c2[0] = 4'b1010; c2[1] = 4'b1111; c2[2] = 4'b1000; c2[3] = 4'b1100;
    doPooling2 = 1'b1;
    control2   = pack16(c2) & 64'hFFFF;
    model_step(2, 1'b1, i2, c2, st2);
    cycle(1'b1, ipv, cv);
    tests_run++;
    if (op2 !== 16'h8C93) begin
      tests_failed++;
      $display("FAIL self_pair_result: op=%h expected %h", op2, 16'h8C93);
    end
    tests_run++;
    if (op2 !== 16'(pack16(st2))) begin
      tests_failed++;
      $display("FAIL self_pair_model: op=%h expected %h", op2, 16'(pack16(st2)));
    end
    doPooling2 = 1'b0;
  endtask

  task automatic test_load_override();
    int ipv[16];
    int cv[16];
    load_ramp();
    for (int j = 0; j < 16; j++) begin ipv[j] = 7; cv[j] = 4'b1000; end
    cycle(1'b0, ipv, cv);
    tests_run++;
    if (op !== {16{4'h7}}) begin
      tests_failed++;
      $display("FAIL load_override: op=%h expected %h", op, {16{4'h7}});
    end
  endtask

  task automatic test_reset_abort();
    int ipv[16];
    int cv[16];
    load_ramp();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 16; j++) begin ipv[j] = 0; cv[j] = 8 + k; end
      cycle(1'b1, ipv, cv);
    end
    #2;
    RST_N = 1'b0;
    for (int j = 0; j < 16; j++) st[j] = 0;
    #2;
    tests_run++;
    if (op !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_abort_clear: op=%h expected %h", op, 64'h0);
    end
    RST_N = 1'b1;
    for (int j = 0; j < 16; j++) cv[j] = 4'b1011;
    cycle(1'b1, ipv, cv);
    tests_run++;
    if (op !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_abort_no_residue: op=%h expected %h", op, 64'h0);
    end
  endtask

  task automatic test_random();
    int ipv[16];
    int cv[16];
    bit dop;
    int errs;
    errs = 0;
    for (int n = 0; n < 300; n++) begin
      dop = ($urandom_range(0, 9) >= 3);
      for (int j = 0; j < 16; j++) begin
        ipv[j] = $urandom_range(0, 15);
        cv[j]  = $urandom_range(0, 15);
      end
      cycle(dop, ipv, cv);
      tests_run++;
      if (op !== pack16(st)) begin
        tests_failed++;
        errs++;
        if (errs <= 5)
          $display("FAIL random_step%0d: op=%h expected %h", n, op, pack16(st));
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_max_stage();
    test_full_reduction();
    test_avg();
    test_mixed_hold();
    test_self_pair();
    test_load_override();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
